// File: rtl/rdcla_arbiter.sv
// Round-robin arbiter sharing one 64-bit recursive-doubling carry-lookahead
// adder among NREQ valid/ready requesters, with a single registered result slot.

module rdcla (
   input  logic [63:0] i_a,
   input  logic [63:0] i_b,
   input  logic        i_cin,
   output logic [63:0] o_sum,
   output logic        o_cout
);
   logic [63:0] w_p;
   logic [63:0] w_g0;
   logic [63:0] w_gl [0:6];
   logic [63:0] w_pl [0:6];

   assign w_p  = i_a ^ i_b;
   // Carry-in folded into bit 0 generate so the prefix tree yields every carry directly.
   assign w_g0 = (i_a & i_b) | {63'd0, w_p[0] & i_cin};

   always_comb begin
      w_gl[0] = w_g0;
      w_pl[0] = w_p;
      for (int l = 0; l < 6; l++) begin
         w_gl[l+1] = w_gl[l] | (w_pl[l] & (w_gl[l] << (1 << l)));
         w_pl[l+1] = w_pl[l] & ((w_pl[l] << (1 << l)) | ((64'd1 << (1 << l)) - 64'd1));
      end
   end

   assign o_sum  = w_p ^ {w_gl[6][62:0], i_cin};
   assign o_cout = w_gl[6][63];
endmodule

module rdcla_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*64-1:0]   req_a,
   input  logic [NREQ*64-1:0]   req_b,
   input  logic [NREQ-1:0]      req_cin,
   input  logic [NREQ-1:0]      req_sub,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [IDW-1:0]       res_id,
   output logic [63:0]          res_sum,
   output logic                 res_cout,
   output logic                 res_ovf,
   output logic [31:0]          op_count
);
   logic            r_valid;
   logic [IDW-1:0]  r_id;
   logic [63:0]     r_sum;
   logic            r_cout;
   logic            r_ovf;
   logic [IDW-1:0]  r_ptr;
   logic [31:0]     r_op_count;

   logic            w_found;
   logic [IDW-1:0]  w_gidx;
   logic            w_slot_free;
   logic            w_xfer;
   logic [63:0]     w_a;
   logic [63:0]     w_b;
   logic            w_cin;
   logic            w_sub;
   logic [63:0]     w_bop;
   logic            w_add_cin;
   logic [63:0]     w_sum;
   logic            w_cout;
   logic            w_ovf;
   logic [IDW-1:0]  w_ptr_nxt;

   // Scan from the highest rotated offset down so the nearest valid index after ptr wins.
   always_comb begin
      int w_cand;
      w_cand  = 0;
      w_found = 1'b0;
      w_gidx  = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_cand = int'(r_ptr) + k;
         if (w_cand >= NREQ) w_cand = w_cand - NREQ;
         for (int i = 0; i < NREQ; i++) begin
            if (i == w_cand && req_valid[i]) begin
               w_found = 1'b1;
               w_gidx  = IDW'(i);
            end
         end
      end
   end

   assign w_slot_free = !r_valid || res_ready;
   assign w_xfer      = w_found && w_slot_free;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = w_xfer && (w_gidx == IDW'(i));
      end
   end

   always_comb begin
      w_a   = '0;
      w_b   = '0;
      w_cin = 1'b0;
      w_sub = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gidx == IDW'(i)) begin
            w_a   = req_a[64*i +: 64];
            w_b   = req_b[64*i +: 64];
            w_cin = req_cin[i];
            w_sub = req_sub[i];
         end
      end
   end

   assign w_bop     = w_sub ? ~w_b : w_b;
   assign w_add_cin = w_sub | w_cin;

   rdcla u_rdcla (
      .i_a    (w_a),
      .i_b    (w_bop),
      .i_cin  (w_add_cin),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   assign w_ovf     = (w_a[63] == w_bop[63]) && (w_sum[63] != w_a[63]);
   assign w_ptr_nxt = (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_id       <= '0;
         r_sum      <= '0;
         r_cout     <= 1'b0;
         r_ovf      <= 1'b0;
         r_ptr      <= '0;
         r_op_count <= '0;
      end else begin
         if (w_xfer) begin
            r_valid    <= 1'b1;
            r_id       <= w_gidx;
            r_sum      <= w_sum;
            r_cout     <= w_cout;
            r_ovf      <= w_ovf;
            r_ptr      <= w_ptr_nxt;
            r_op_count <= r_op_count + 32'd1;
         end else if (res_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign res_valid = r_valid;
   assign res_id    = r_id;
   assign res_sum   = r_sum;
   assign res_cout  = r_cout;
   assign res_ovf   = r_ovf;
   assign op_count  = r_op_count;
endmodule

// File: tb/tb_rdcla_arbiter.sv
// Bench for rdcla_arbiter: fixed vectors, hand-written multi-cycle sequences,
// then randomized traffic against a behavioural reference model.

module tb_rdcla_arbiter;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                clk;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*64-1:0]  req_a;
   logic [NREQ*64-1:0]  req_b;
   logic [NREQ-1:0]     req_cin;
   logic [NREQ-1:0]     req_sub;
   logic                res_valid;
   logic                res_ready;
   logic [IDW-1:0]      res_id;
   logic [63:0]         res_sum;
   logic                res_cout;
   logic                res_ovf;
   logic [31:0]         op_count;

   rdcla_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .req_sub   (req_sub),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_id    (res_id),
      .res_sum   (res_sum),
      .res_cout  (res_cout),
      .res_ovf   (res_ovf),
      .op_count  (op_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   typedef struct {
      int          id;
      logic [63:0] a;
      logic [63:0] b;
      logic        cin;
      logic        sub;
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t vt [8];

   // Reference arithmetic: exact integer sum/difference, overflow = out of signed 64-bit range.
   function automatic void ref_calc(input logic [63:0] a, input logic [63:0] b,
                                    input logic cin, input logic sub,
                                    output logic [63:0] sum, output logic cout,
                                    output logic ovf);
      logic [65:0] ea, eb, s;
      ea = {{2{a[63]}}, a};
      eb = {{2{b[63]}}, b};
      if (sub) begin
         s    = ea - eb;
         sum  = a - b;
         cout = (a >= b);
      end else begin
         s           = ea + eb + 66'(cin);
         {cout, sum} = {1'b0, a} + {1'b0, b} + 65'(cin);
      end
      ovf = (s[65:63] != 3'b000) && (s[65:63] != 3'b111);
   endfunction

   function automatic int mgrant(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [63:0] rnd_val();
      case ($urandom_range(0, 5))
         0:       return 64'hFFFF_FFFF_FFFF_FFFF;
         1:       return 64'h8000_0000_0000_0000;
         2:       return 64'h7FFF_FFFF_FFFF_FFFF;
         default: return {$urandom(), $urandom()};
      endcase
   endfunction

   logic [63:0] pa [NREQ];
   logic [63:0] pb [NREQ];
   logic [NREQ-1:0] pcin, psub, pend;

   task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sub);
      req_a[64*i +: 64] = a;
      req_b[64*i +: 64] = b;
      req_cin[i]        = cin;
      req_sub[i]        = sub;
      pa[i] = a;
      pb[i] = b;
      pcin[i] = cin;
      psub[i] = sub;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      req_valid = '0;
      res_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic        m_valid;
   logic [63:0] m_sum;
   logic        m_cout, m_ovf;
   int          m_id, m_ptr;
   logic [31:0] m_cnt;
   logic [63:0] e_sum;
   logic        e_cout, e_ovf;
   int          rr_exp [14];
   int          g;

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_cin   = '0;
      req_sub   = '0;
      res_ready = 1'b1;
      pend      = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      chk("rst_valid", 64'(res_valid), 64'd0);
      chk("rst_sum",   res_sum, 64'd0);
      chk("rst_cout",  64'(res_cout), 64'd0);
      chk("rst_ovf",   64'(res_ovf), 64'd0);
      chk("rst_id",    64'(res_id), 64'd0);
      chk("rst_cnt",   64'(op_count), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);

      vt[0] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0};
      vt[1] = '{2, 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
      vt[2] = '{2, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      vt[3] = '{1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1};
      vt[4] = '{3, 64'd10, 64'd20, 1'b1, 1'b0, 64'd31, 1'b0, 1'b0};
      vt[5] = '{1, 64'd100, 64'd100, 1'b1, 1'b1, 64'd0, 1'b1, 1'b0};
      vt[6] = '{0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
                64'd0, 1'b1, 1'b1};
      vt[7] = '{3, 64'd0, 64'd0, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0};

      for (int r = 0; r < 8; r++) begin
         set_op(vt[r].id, vt[r].a, vt[r].b, vt[r].cin, vt[r].sub);
         req_valid = NREQ'(1) << vt[r].id;
         res_ready = 1'b1;
         #1;
         chk("vec_ready", 64'(req_ready), 64'(NREQ'(1) << vt[r].id));
         @(posedge clk);
         @(negedge clk);
         req_valid = '0;
         chk("vec_valid", 64'(res_valid), 64'd1);
         chk("vec_sum",   res_sum, vt[r].sum);
         chk("vec_cout",  64'(res_cout), 64'(vt[r].cout));
         chk("vec_ovf",   64'(res_ovf), 64'(vt[r].ovf));
         chk("vec_id",    64'(res_id), 64'(vt[r].id));
         chk("vec_cnt",   64'(op_count), 64'(r + 1));
      end
      @(negedge clk);
      chk("vec_drain", 64'(res_valid), 64'd0);

      // Round-robin with all requesters valid; req 1 drops right after a transfer.
      do_reset();
      rr_exp = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0, 2, 3};
      for (int i = 0; i < NREQ; i++) begin
         set_op(i, 64'h0123_4567_89AB_CDEF * 64'(i + 1), 64'hF0F0_0000_1234_5678 ^ 64'(i),
                1'(i % 2), 1'(i / 2));
      end
      req_valid = '1;
      res_ready = 1'b1;
      for (int k = 0; k < 14; k++) begin
         if (k == 6) req_valid[1] = 1'b0;
         #1;
         chk("rr_ready", 64'(req_ready), 64'(NREQ'(1) << rr_exp[k]));
         @(posedge clk);
         @(negedge clk);
         ref_calc(pa[rr_exp[k]], pb[rr_exp[k]], pcin[rr_exp[k]], psub[rr_exp[k]],
                  e_sum, e_cout, e_ovf);
         chk("rr_valid", 64'(res_valid), 64'd1);
         chk("rr_id",    64'(res_id), 64'(rr_exp[k]));
         chk("rr_sum",   res_sum, e_sum);
      end

      // Backpressure: result from req 3 must hold, nothing accepted.
      ref_calc(pa[3], pb[3], pcin[3], psub[3], e_sum, e_cout, e_ovf);
      res_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_ready", 64'(req_ready), 64'd0);
         @(posedge clk);
         @(negedge clk);
         chk("bp_valid", 64'(res_valid), 64'd1);
         chk("bp_sum",   res_sum, e_sum);
         chk("bp_id",    64'(res_id), 64'd3);
         chk("bp_cnt",   64'(op_count), 64'd14);
      end
      res_ready = 1'b1;
      #1;
      chk("bp_release_ready", 64'(req_ready), 64'b0001);
      @(posedge clk);
      @(negedge clk);
      ref_calc(pa[0], pb[0], pcin[0], psub[0], e_sum, e_cout, e_ovf);
      chk("bp_release_valid", 64'(res_valid), 64'd1);
      chk("bp_release_id",    64'(res_id), 64'd0);
      chk("bp_release_sum",   res_sum, e_sum);
      chk("bp_release_cnt",   64'(op_count), 64'd15);

      // Asynchronous reset between edges while a result is held (ptr is 1 here).
      #3;
      rst = 1'b1;
      #1;
      chk("mrst_valid", 64'(res_valid), 64'd0);
      chk("mrst_cnt",   64'(op_count), 64'd0);
      chk("mrst_sum",   res_sum, 64'd0);
      chk("mrst_id",    64'(res_id), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("mrst_hold_valid", 64'(res_valid), 64'd0);
      rst = 1'b0;
      #1;
      chk("mrst_ready", 64'(req_ready), 64'b0001);
      @(posedge clk);
      @(negedge clk);
      chk("mrst_id2",  64'(res_id), 64'd0);
      chk("mrst_cnt2", 64'(op_count), 64'd1);

      // op_count wrap via backdoor preload.
      req_valid = '0;
      force dut.r_op_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_op_count;
      req_valid = 4'b0100;
      #1;
      chk("wrap_ready", 64'(req_ready), 64'b0100);
      @(posedge clk);
      @(negedge clk);
      chk("wrap_cnt",   64'(op_count), 64'd0);
      chk("wrap_id",    64'(res_id), 64'd2);

      // Randomized traffic against the reference model.
      do_reset();
      m_valid = 1'b0;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_ovf   = 1'b0;
      m_id    = 0;
      m_ptr   = 0;
      m_cnt   = '0;
      pend    = '0;
      for (int c = 0; c < 300; c++) begin
         chk("rnd_valid", 64'(res_valid), 64'(m_valid));
         chk("rnd_sum",   res_sum, m_sum);
         chk("rnd_cout",  64'(res_cout), 64'(m_cout));
         chk("rnd_ovf",   64'(res_ovf), 64'(m_ovf));
         chk("rnd_id",    64'(res_id), 64'(m_id));
         chk("rnd_cnt",   64'(op_count), 64'(m_cnt));
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i] = 1'b1;
               set_op(i, rnd_val(), rnd_val(), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
            end
         end
         res_ready = ($urandom_range(0, 3) != 0);
         req_valid = pend;
         #1;
         g = (!m_valid || res_ready) ? mgrant(pend, m_ptr) : -1;
         chk("rnd_ready", 64'(req_ready), (g >= 0) ? 64'(NREQ'(1) << g) : 64'd0);
         @(posedge clk);
         if (g >= 0) begin
            ref_calc(pa[g], pb[g], pcin[g], psub[g], m_sum, m_cout, m_ovf);
            m_valid = 1'b1;
            m_id    = g;
            m_ptr   = (g + 1) % NREQ;
            m_cnt   = m_cnt + 32'd1;
            pend[g] = 1'b0;
         end else if (res_ready) begin
            m_valid = 1'b0;
         end
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
